// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: issues one outstanding req/ack fetch at a time into a DEPTH-entry
// prefetch FIFO of {instr, pc}, with redirect flush, halt freeze and IF/ID back-pressure.
module fetch_prefetch_unit #(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 16,
    parameter int              DEPTH    = 4,
    parameter int              PC_INC   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_ack,
    input  logic [INSTR_W-1:0]         mem_rdata,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    input  logic                       halt,
    output logic                       if_valid,
    input  logic                       if_ready,
    output logic [INSTR_W-1:0]         if_instr,
    output logic [ADDR_W-1:0]          if_pc,
    output logic [ADDR_W-1:0]          if_pc_next,
    output logic [ADDR_W-1:0]          fetch_pc,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_KILL, S_HALTED} state_t;

    state_t                       state_q;
    logic [ADDR_W-1:0]            fetch_pc_q;
    logic [ADDR_W-1:0]            kill_addr_q;
    logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [CNT_W:0]               cnt_nxt;
    logic [DEPTH-1:0][INSTR_W-1:0] instr_q;
    logic [DEPTH-1:0][ADDR_W-1:0]  pc_q;
    logic                         push, pop, room;

    assign if_valid = (cnt_q != '0);
    assign pop      = if_valid & if_ready & ~redirect;
    assign push     = mem_ack & (state_q == S_WAIT) & ~redirect;

    // Room accounts for this cycle's push/pop so a newly issued request always has a free slot.
    assign cnt_nxt  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};
    assign room     = (cnt_nxt < (CNT_W+1)'(DEPTH)) & ~halt;
    assign cnt_d    = cnt_nxt[CNT_W-1:0];

    assign mem_req    = (state_q == S_WAIT) | (state_q == S_KILL);
    assign mem_addr   = (state_q == S_KILL) ? kill_addr_q : fetch_pc_q;
    assign fetch_pc   = fetch_pc_q;
    assign fifo_count = cnt_q;
    assign if_instr   = if_valid ? instr_q[rd_ptr_q] : '0;
    assign if_pc      = if_valid ? pc_q[rd_ptr_q] : '0;
    assign if_pc_next = if_valid ? pc_q[rd_ptr_q] + ADDR_W'(PC_INC) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            kill_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (redirect)  fetch_pc_q <= redirect_pc;
                    else if (halt) state_q    <= S_HALTED;
                    else if (room) state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (redirect) begin
                        fetch_pc_q <= redirect_pc;
                        if (mem_ack) begin
                            state_q <= S_IDLE;
                        end else begin
                            // The in-flight request must complete on its original address.
                            state_q     <= S_KILL;
                            kill_addr_q <= fetch_pc_q;
                        end
                    end else if (mem_ack) begin
                        fetch_pc_q <= fetch_pc_q + ADDR_W'(PC_INC);
                        if (room)      state_q <= S_WAIT;
                        else if (halt) state_q <= S_HALTED;
                        else           state_q <= S_IDLE;
                    end
                end
                S_KILL: begin
                    if (redirect) fetch_pc_q <= redirect_pc;
                    if (mem_ack)  state_q    <= S_IDLE;
                end
                S_HALTED: begin
                    if (redirect) begin
                        fetch_pc_q <= redirect_pc;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (redirect) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr_q] <= mem_rdata;
            pc_q[wr_ptr_q]    <= fetch_pc_q;
        end
    end
endmodule
